// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670-style camera frame generator:
// geometry defaults, pattern select codes, colour-bar constants and FSM states.
package cam_pkg;

    // Frame geometry defaults (160x120 RGB444, two bytes per pixel)
    localparam int unsigned TAM_LINE_DEF       = 320;
    localparam int unsigned TAM_ROW_DEF        = 120;
    localparam int unsigned BLACK_TAM_LINE_DEF = 4;
    localparam int unsigned BLACK_TAM_ROW_DEF  = 4;
    localparam int unsigned PCLK_DIV_DEF       = 2;

    localparam int unsigned RGB_W    = 12;
    localparam int unsigned NUM_BARS = 8;

    // Pattern select codes
    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_RAMP  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    // Colour bars, left to right
    localparam logic [RGB_W-1:0] BAR_WHITE   = 12'hFFF;
    localparam logic [RGB_W-1:0] BAR_YELLOW  = 12'hFF0;
    localparam logic [RGB_W-1:0] BAR_CYAN    = 12'h0FF;
    localparam logic [RGB_W-1:0] BAR_GREEN   = 12'h0F0;
    localparam logic [RGB_W-1:0] BAR_MAGENTA = 12'hF0F;
    localparam logic [RGB_W-1:0] BAR_RED     = 12'hF00;
    localparam logic [RGB_W-1:0] BAR_BLUE    = 12'h00F;
    localparam logic [RGB_W-1:0] BAR_BLACK   = 12'h000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Colour of bar number idx
    function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
        logic [RGB_W-1:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cam_pixel_pattern.sv
// Combinational test-pattern generator: pixel coordinate -> RGB444 colour.
// Ports:
//   x, y     - pixel column / row inside the active window
//   pattern  - 0 solid, 1 colour bars, 2 index ramp, 3 checkerboard
//   color    - solid colour for pattern 0
//   rgb_c    - resulting {R,G,B} value
module cam_pixel_pattern
    import cam_pkg::*;
#(
    parameter int unsigned XW      = 8,
    parameter int unsigned YW      = 7,
    parameter int unsigned PX_LINE = 160
) (
    input  logic [XW-1:0]    x,
    input  logic [YW-1:0]    y,
    input  logic [1:0]       pattern,
    input  logic [RGB_W-1:0] color,
    output logic [RGB_W-1:0] rgb_c
);

    localparam int unsigned BAR_W = (PX_LINE >= NUM_BARS) ? PX_LINE / NUM_BARS : 1;

    logic [XW-1:0] bar_full;
    logic [2:0]    bar_idx;

    always_comb begin
        bar_full = x / XW'(BAR_W);
        // Columns past the last full bar stay in the last bar
        bar_idx  = (bar_full > XW'(NUM_BARS - 1)) ? 3'(NUM_BARS - 1) : 3'(bar_full);
        case (pattern)
            PAT_SOLID: rgb_c = color;
            PAT_BARS:  rgb_c = bar_color(bar_idx);
            // Linear pixel index, truncated to 12 bits (mod 4096)
            PAT_RAMP:  rgb_c = 12'(y) * 12'(PX_LINE) + 12'(x);
            default:   rgb_c = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
        endcase
    end

endmodule

// File: rtl/cam_frame_gen.sv
// OV7670-style camera transmitter used in place of the sensor for loopback.
// Emits pixel clock, vsync, href and RGB444 bytes (two per pixel) with
// blank lines at the start of each frame and blank slots at the end of each line.
// Ports:
//   clk, rst          - system clock, synchronous active-low reset
//   en                - frame generation enable (checked at frame boundaries)
//   pattern, color    - test pattern select and solid colour, latched per frame
//   CAM_pclk          - generated pixel clock
//   CAM_vsync         - frame sync, active high
//   CAM_href          - line valid, active high
//   CAM_px_data       - pixel byte
//   frame_start       - one-clk pulse when row 0 / slot 0 is issued
//   frame_done        - one-clk pulse when the last slot of the frame is issued
module cam_frame_gen
    import cam_pkg::*;
#(
    parameter int unsigned TAM_LINE       = TAM_LINE_DEF,
    parameter int unsigned TAM_ROW        = TAM_ROW_DEF,
    parameter int unsigned BLACK_TAM_LINE = BLACK_TAM_LINE_DEF,
    parameter int unsigned BLACK_TAM_ROW  = BLACK_TAM_ROW_DEF,
    parameter int unsigned PCLK_DIV       = PCLK_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       pattern,
    input  logic [RGB_W-1:0] color,
    output logic             CAM_pclk,
    output logic             CAM_vsync,
    output logic             CAM_href,
    output logic [7:0]       CAM_px_data,
    output logic             frame_start,
    output logic             frame_done
);

    localparam int unsigned LINE_TOT = TAM_LINE + BLACK_TAM_LINE;
    localparam int unsigned ROW_TOT  = TAM_ROW + BLACK_TAM_ROW;
    localparam int unsigned LW       = (LINE_TOT > 1) ? $clog2(LINE_TOT) : 1;
    localparam int unsigned RW       = (ROW_TOT > 1) ? $clog2(ROW_TOT) : 1;
    localparam int unsigned DW       = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam int unsigned XW       = (LW > 4) ? LW - 1 : 4;
    localparam int unsigned YW       = (RW > 4) ? RW : 4;
    localparam int unsigned PX_LINE  = TAM_LINE / 2;
    localparam int unsigned VS_ROWS  = BLACK_TAM_ROW / 2;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q;
    logic [LW-1:0]    line_q, line_d;
    logic [RW-1:0]    row_q, row_d;
    logic [1:0]       pat_q, pat_sel;
    logic [RGB_W-1:0] color_q, color_sel, rgb_c;
    logic             div_wrap_c, fall_c, last_c, start_c, done_c;
    logic             run_d, vsync_d, href_d;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [7:0]       byte_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and slot counters; everything moves only on a pclk falling event
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        row_d      = row_q;
        start_c    = 1'b0;
        div_wrap_c = (div_q == DW'(PCLK_DIV - 1));
        fall_c     = CAM_pclk && div_wrap_c;
        last_c     = (line_q == LW'(LINE_TOT - 1)) && (row_q == RW'(ROW_TOT - 1));
        case (state_q)
            ST_IDLE: begin
                if (fall_c && en) begin
                    state_d = ST_RUN;
                    line_d  = '0;
                    row_d   = '0;
                    start_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (fall_c) begin
                    if (last_c) begin
                        line_d = '0;
                        row_d  = '0;
                        if (en) begin
                            start_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (line_q == LW'(LINE_TOT - 1)) begin
                        line_d = '0;
                        row_d  = row_q + RW'(1);
                    end else begin
                        line_d = line_q + LW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the slot about to be issued
    always_comb begin
        run_d     = (state_d == ST_RUN);
        vsync_d   = run_d && (row_d < RW'(VS_ROWS));
        href_d    = run_d && (row_d >= RW'(BLACK_TAM_ROW)) && (line_d < LW'(TAM_LINE));
        done_c    = fall_c && run_d && (line_d == LW'(LINE_TOT - 1))
                    && (row_d == RW'(ROW_TOT - 1));
        // A starting frame already uses the freshly sampled pattern/colour
        pat_sel   = start_c ? pattern : pat_q;
        color_sel = start_c ? color : color_q;
        x         = XW'(line_d >> 1);
        y         = YW'(row_d - RW'(BLACK_TAM_ROW));
        byte_d    = line_d[0] ? rgb_c[7:0] : {4'h0, rgb_c[11:8]};
    end

    cam_pixel_pattern #(
        .XW      (XW),
        .YW      (YW),
        .PX_LINE (PX_LINE)
    ) u_pattern (
        .x       (x),
        .y       (y),
        .pattern (pat_sel),
        .color   (color_sel),
        .rgb_c   (rgb_c)
    );

    // Pixel clock divider, counters and registered camera outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q       <= '0;
            CAM_pclk    <= 1'b0;
            line_q      <= '0;
            row_q       <= '0;
            pat_q       <= PAT_SOLID;
            color_q     <= '0;
            CAM_vsync   <= 1'b0;
            CAM_href    <= 1'b0;
            CAM_px_data <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            if (div_wrap_c) begin
                div_q    <= '0;
                CAM_pclk <= ~CAM_pclk;
            end else begin
                div_q <= div_q + DW'(1);
            end
            line_q      <= line_d;
            row_q       <= row_d;
            frame_start <= start_c;
            frame_done  <= done_c;
            if (start_c) begin
                pat_q   <= pattern;
                color_q <= color;
            end
            if (fall_c) begin
                CAM_vsync   <= vsync_d;
                CAM_href    <= href_d;
                CAM_px_data <= href_d ? byte_d : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_gen.sv
// Self-checking bench for cam_frame_gen: reset/idle, frame geometry,
// colour bars, ramp, checkerboard, back-to-back, stop and mid-frame reset.
module tb_cam_frame_gen;

    localparam int unsigned TAM_LINE       = 320;
    localparam int unsigned TAM_ROW        = 3;
    localparam int unsigned BLACK_TAM_LINE = 4;
    localparam int unsigned BLACK_TAM_ROW  = 4;
    localparam int unsigned PCLK_DIV       = 2;
    localparam int          LINE_TOT       = 324;
    localparam int          FRAME          = 324 * 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] pattern;
    logic [11:0] color;
    logic       CAM_pclk;
    logic       CAM_vsync;
    logic       CAM_href;
    logic [7:0] CAM_px_data;
    logic       frame_start;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic       cap_vs [FRAME];
    logic       cap_hr [FRAME];
    logic       cap_st [FRAME];
    logic       cap_dn [FRAME];
    logic [7:0] cap_d  [FRAME];

    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    always #5 clk = ~clk;

    cam_frame_gen #(
        .TAM_LINE       (TAM_LINE),
        .TAM_ROW        (TAM_ROW),
        .BLACK_TAM_LINE (BLACK_TAM_LINE),
        .BLACK_TAM_ROW  (BLACK_TAM_ROW),
        .PCLK_DIV       (PCLK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pattern     (pattern),
        .color       (color),
        .CAM_pclk    (CAM_pclk),
        .CAM_vsync   (CAM_vsync),
        .CAM_href    (CAM_href),
        .CAM_px_data (CAM_px_data),
        .frame_start (frame_start),
        .frame_done  (frame_done)
    );

    // Advance to the next clk edge where CAM_pclk goes 1->0
    task automatic wait_fall();
        int   n;
        logic p;
        n = 0;
        p = CAM_pclk;
        forever begin
            @(posedge clk); #1;
            n++;
            if (p === 1'b1 && CAM_pclk === 1'b0) return;
            p = CAM_pclk;
            if (n > 4 * PCLK_DIV + 4) begin
                n_cmp++; n_err++;
                $display("FAIL wait_fall: no pclk falling event within %0d clk", n);
                return;
            end
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (frame_start !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (n > 20000) begin
                n_cmp++; n_err++;
                $display("FAIL wait_start: no frame_start within %0d clk", n);
                return;
            end
        end
    endtask

    // Record one full frame, slot 0 being the current (frame_start) slot
    task automatic capture_frame();
        for (int k = 0; k < FRAME; k++) begin
            if (k != 0) wait_fall();
            cap_vs[k] = CAM_vsync;
            cap_hr[k] = CAM_href;
            cap_st[k] = frame_start;
            cap_dn[k] = frame_done;
            cap_d[k]  = CAM_px_data;
        end
    endtask

    task automatic test_reset();
        int   bad_idle, rises, per_err, last_rise;
        logic prev;
        rst = 1'b0; en = 1'b0; pattern = 2'd0; color = 12'h000;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (CAM_pclk !== 1'b0) begin n_err++; $display("FAIL reset_pclk: got %b expected 0", CAM_pclk); end
        n_cmp++;
        if ({CAM_vsync, CAM_href, CAM_px_data, frame_start, frame_done} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got vs=%b hr=%b d=%h st=%b dn=%b expected all 0",
                     CAM_vsync, CAM_href, CAM_px_data, frame_start, frame_done);
        end
        rst = 1'b1;
        bad_idle = 0; rises = 0; per_err = 0; last_rise = -1;
        prev = CAM_pclk;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk); #1;
            if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0 || CAM_px_data !== 8'h00 ||
                frame_start !== 1'b0 || frame_done !== 1'b0) bad_idle++;
            if (prev === 1'b0 && CAM_pclk === 1'b1) begin
                if (last_rise >= 0 && (i - last_rise) != 4) per_err++;
                last_rise = i;
                rises++;
            end
            prev = CAM_pclk;
        end
        n_cmp++;
        if (bad_idle != 0) begin n_err++; $display("FAIL idle_outputs: got %0d active cycles expected 0", bad_idle); end
        n_cmp++;
        if (rises != 500) begin n_err++; $display("FAIL idle_pclk_rises: got %0d expected 500", rises); end
        n_cmp++;
        if (per_err != 0) begin n_err++; $display("FAIL idle_pclk_period: got %0d bad periods expected 0", per_err); end
    endtask

    task automatic test_geometry();
        int   vs_cnt, vs_first_low, rises, first_rise, wid_err, gap_err;
        int   run, gap, done_cnt, done_idx, st_cnt, d_err, d_first;
        int   r, c;
        logic prev_hr;
        logic [7:0] exp_b;
        en = 1'b1; pattern = 2'd0; color = 12'hA5C;
        wait_start();
        // Next frame's settings; must not disturb the frame in progress
        pattern = 2'd1; color = 12'h000;
        capture_frame();
        vs_cnt = 0; vs_first_low = -1; rises = 0; first_rise = -1; wid_err = 0; gap_err = 0;
        run = 0; gap = 0; done_cnt = 0; done_idx = -1; st_cnt = 0; d_err = 0; d_first = -1;
        prev_hr = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            r = k / LINE_TOT;
            c = k % LINE_TOT;
            if (cap_vs[k]) vs_cnt++;
            else if (vs_first_low < 0) vs_first_low = k;
            if (cap_hr[k]) begin
                if (!prev_hr) begin
                    rises++;
                    if (first_rise < 0) first_rise = k;
                    else if (gap != 4) gap_err++;
                end
                run++;
            end else begin
                if (prev_hr) begin
                    if (run != 320) wid_err++;
                    run = 0;
                    gap = 0;
                end
                gap++;
            end
            prev_hr = cap_hr[k];
            if (cap_dn[k]) begin done_cnt++; done_idx = k; end
            if (k > 0 && cap_st[k]) st_cnt++;
            if (r >= 4 && c < 320) exp_b = (c % 2 == 0) ? 8'h0A : 8'h5C;
            else exp_b = 8'h00;
            if (cap_d[k] !== exp_b) begin
                d_err++;
                if (d_first < 0) d_first = k;
            end
        end
        n_cmp++; if (vs_cnt != 648) begin n_err++; $display("FAIL geom_vsync_len: got %0d expected 648", vs_cnt); end
        n_cmp++; if (vs_first_low != 648) begin n_err++; $display("FAIL geom_vsync_end: got %0d expected 648", vs_first_low); end
        n_cmp++; if (rises != 3) begin n_err++; $display("FAIL geom_href_count: got %0d expected 3", rises); end
        n_cmp++; if (first_rise != 1296) begin n_err++; $display("FAIL geom_href_first: got %0d expected 1296", first_rise); end
        n_cmp++; if (wid_err != 0) begin n_err++; $display("FAIL geom_href_width: got %0d bad widths expected 0", wid_err); end
        n_cmp++; if (gap_err != 0) begin n_err++; $display("FAIL geom_href_gap: got %0d bad gaps expected 0", gap_err); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL geom_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_idx != FRAME - 1) begin n_err++; $display("FAIL geom_done_slot: got %0d expected %0d", done_idx, FRAME - 1); end
        n_cmp++; if (st_cnt != 0) begin n_err++; $display("FAIL geom_extra_start: got %0d expected 0", st_cnt); end
        n_cmp++;
        if (d_err != 0) begin
            n_err++;
            $display("FAIL geom_solid_bytes: got %0d bad bytes (first slot %0d = %h) expected 0",
                     d_err, d_first, cap_d[d_first]);
        end
    endtask

    task automatic test_back_to_back();
        n_cmp++;
        if (frame_done !== 1'b1) begin n_err++; $display("FAIL btb_done_now: got %b expected 1", frame_done); end
        @(posedge clk); #1;
        n_cmp++;
        if (frame_done !== 1'b0) begin n_err++; $display("FAIL btb_done_width: got %b expected 0", frame_done); end
        wait_fall();
        n_cmp++;
        if (frame_start !== 1'b1) begin n_err++; $display("FAIL btb_start: got %b expected 1", frame_start); end
    endtask

    task automatic test_bars();
        int          off [6];
        logic [7:0]  exb [6];
        int          base, d_err, d_first, r, c;
        logic [11:0] rgb;
        logic [7:0]  exp_b;
        pattern = 2'd2;
        capture_frame();
        off = '{0, 1, 40, 41, 280, 319};
        exb = '{8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'h00};
        base = 4 * LINE_TOT;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (cap_d[base + off[i]] !== exb[i]) begin
                n_err++;
                $display("FAIL bars_byte_%0d: got %h expected %h", off[i], cap_d[base + off[i]], exb[i]);
            end
        end
        d_err = 0; d_first = -1;
        for (int k = 0; k < FRAME; k++) begin
            r = k / LINE_TOT;
            c = k % LINE_TOT;
            rgb = bars[(c / 2) / 20 > 7 ? 7 : (c / 2) / 20];
            if (r >= 4 && c < 320) exp_b = (c % 2 == 0) ? {4'h0, rgb[11:8]} : rgb[7:0];
            else exp_b = 8'h00;
            if (cap_d[k] !== exp_b) begin d_err++; if (d_first < 0) d_first = k; end
        end
        n_cmp++;
        if (d_err != 0) begin n_err++; $display("FAIL bars_all: got %0d bad bytes (first slot %0d) expected 0", d_err, d_first); end
    endtask

    task automatic test_ramp();
        int          row [6];
        int          col [6];
        logic [7:0]  exb [6];
        int          d_err, d_first, r, c;
        logic [11:0] v;
        logic [7:0]  exp_b;
        wait_fall();
        n_cmp++;
        if (frame_start !== 1'b1) begin n_err++; $display("FAIL ramp_start: got %b expected 1", frame_start); end
        pattern = 2'd3;
        capture_frame();
        row = '{5, 5, 4, 4, 6, 5};
        col = '{0, 1, 2, 3, 319, 319};
        exb = '{8'h00, 8'hA0, 8'h00, 8'h01, 8'hDF, 8'h3F};
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (cap_d[row[i] * LINE_TOT + col[i]] !== exb[i]) begin
                n_err++;
                $display("FAIL ramp_r%0d_c%0d: got %h expected %h", row[i], col[i],
                         cap_d[row[i] * LINE_TOT + col[i]], exb[i]);
            end
        end
        d_err = 0; d_first = -1;
        for (int k = 0; k < FRAME; k++) begin
            r = k / LINE_TOT;
            c = k % LINE_TOT;
            v = 12'(((r - 4) * 160 + c / 2) % 4096);
            if (r >= 4 && c < 320) exp_b = (c % 2 == 0) ? {4'h0, v[11:8]} : v[7:0];
            else exp_b = 8'h00;
            if (cap_d[k] !== exp_b) begin d_err++; if (d_first < 0) d_first = k; end
        end
        n_cmp++;
        if (d_err != 0) begin n_err++; $display("FAIL ramp_all: got %0d bad bytes (first slot %0d) expected 0", d_err, d_first); end
    endtask

    task automatic test_checker();
        int          col [6];
        logic [7:0]  exb [6];
        int          base, d_err, d_first, done_cnt, r, c, x;
        logic [7:0]  exp_b;
        wait_fall();
        n_cmp++;
        if (frame_start !== 1'b1) begin n_err++; $display("FAIL check_start: got %b expected 1", frame_start); end
        en = 1'b0;
        capture_frame();
        col = '{16, 17, 14, 15, 48, 49};
        exb = '{8'h0F, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'hFF};
        base = 4 * LINE_TOT;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (cap_d[base + col[i]] !== exb[i]) begin
                n_err++;
                $display("FAIL check_byte_%0d: got %h expected %h", col[i], cap_d[base + col[i]], exb[i]);
            end
        end
        d_err = 0; d_first = -1; done_cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            r = k / LINE_TOT;
            c = k % LINE_TOT;
            x = c / 2;
            if (r >= 4 && c < 320 && (((x / 8) % 2) != (((r - 4) / 8) % 2)))
                exp_b = (c % 2 == 0) ? 8'h0F : 8'hFF;
            else exp_b = 8'h00;
            if (cap_d[k] !== exp_b) begin d_err++; if (d_first < 0) d_first = k; end
            if (cap_dn[k]) done_cnt++;
        end
        n_cmp++;
        if (d_err != 0) begin n_err++; $display("FAIL check_all: got %0d bad bytes (first slot %0d) expected 0", d_err, d_first); end
        n_cmp++;
        if (cap_dn[FRAME - 1] !== 1'b1 || done_cnt != 1) begin
            n_err++;
            $display("FAIL stop_frame_completes: got done_last=%b count=%0d expected 1/1", cap_dn[FRAME - 1], done_cnt);
        end
    endtask

    task automatic test_stop();
        int   bad, rises;
        logic prev;
        wait_fall();
        n_cmp++;
        if ({frame_start, CAM_vsync, CAM_href} !== 3'b000) begin
            n_err++;
            $display("FAIL stop_idle: got st=%b vs=%b hr=%b expected 000", frame_start, CAM_vsync, CAM_href);
        end
        bad = 0; rises = 0;
        prev = CAM_pclk;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (frame_start !== 1'b0 || CAM_vsync !== 1'b0 || CAM_href !== 1'b0 ||
                CAM_px_data !== 8'h00) bad++;
            if (prev === 1'b0 && CAM_pclk === 1'b1) rises++;
            prev = CAM_pclk;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL stop_stays_idle: got %0d active cycles expected 0", bad); end
        n_cmp++;
        if (rises != 750) begin n_err++; $display("FAIL stop_pclk_runs: got %0d rises expected 750", rises); end
    endtask

    task automatic test_reset_mid_frame();
        int n, cnt;
        pattern = 2'd0; color = 12'hA5C; en = 1'b1;
        wait_start();
        for (int i = 0; i < 5 * LINE_TOT + 100; i++) wait_fall();
        n_cmp++;
        if (CAM_href !== 1'b1 || CAM_px_data !== 8'h0A) begin
            n_err++;
            $display("FAIL rstmid_before: got hr=%b d=%h expected 1/0a", CAM_href, CAM_px_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_start, frame_done} !== 13'h0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got pclk=%b vs=%b hr=%b d=%h st=%b dn=%b expected all 0",
                     CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_start, frame_done);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        while (frame_start !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n != 4) begin n_err++; $display("FAIL rstmid_restart_delay: got %0d clk expected 4", n); end
        n_cmp++;
        if (CAM_vsync !== 1'b1 || CAM_href !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_row0: got vs=%b hr=%b expected 1/0", CAM_vsync, CAM_href);
        end
        cnt = 0;
        while (CAM_href !== 1'b1 && cnt < 2000) begin
            wait_fall();
            cnt++;
        end
        n_cmp++;
        if (cnt != 1296) begin n_err++; $display("FAIL rstmid_first_href: got %0d periods expected 1296", cnt); end
    endtask

    initial begin
        test_reset();
        test_geometry();
        test_back_to_back();
        test_bars();
        test_ramp();
        test_checker();
        test_stop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cam_frame_gen.md
# cam_frame_gen

Synthesizable OV7670-style camera transmitter. It drives pixel clock, vsync, href and 8-bit RGB444 byte data with the same frame geometry our capture path expects: 160x120 pixels, two bytes per pixel, 4 blank lines, 4 blank byte slots per line. It sits in place of the physical camera on the FPGA. It feeds the capture block's CAM_* inputs for on-board loopback tests of capture, dual-port RAM and VGA.

## Interface
Parameters:
- TAM_LINE, 320: active bytes per line (160 px x 2 bytes)
- TAM_ROW, 120: active lines per frame
- BLACK_TAM_LINE, 4: blank byte slots after the active bytes of each line
- BLACK_TAM_ROW, 4: blank lines at the start of each frame
- PCLK_DIV, 2: clk cycles per CAM_pclk half-period (minimum 1)

Ports:
- clk, in, 1: system clock
- rst, in, 1: synchronous, active-low reset
- en, in, 1: frame generation enable
- pattern, in, 2: 0 solid, 1 colour bars, 2 index ramp, 3 checkerboard
- color, in, 12: RGB444 {R,G,B} value used by pattern 0
- CAM_pclk, out, 1: generated pixel clock
- CAM_vsync, out, 1: frame sync, active high
- CAM_href, out, 1: line valid, active high
- CAM_px_data, out, 8: pixel byte
- frame_start, out, 1: one-clk pulse when row 0 / slot 0 is issued
- frame_done, out, 1: one-clk pulse when the last slot of the last row is issued

## Operation
- FSM states: IDLE and RUN.
- IDLE: counters are 0. Outputs CAM_vsync=0, CAM_href=0, CAM_px_data=0. CAM_pclk keeps toggling.
- IDLE->RUN: on the first pclk falling event with en=1.
- End of frame in RUN: continue to the next frame if en=1, otherwise go to IDLE. en=0 never truncates a frame.
- line_cnt runs 0..TAM_LINE+BLACK_TAM_LINE-1.
- row_cnt runs 0..TAM_ROW+BLACK_TAM_ROW-1.
- line_cnt advances once per pclk period. It wraps to 0 and increments row_cnt. row_cnt wraps at the end of the frame.
- CAM_vsync = 1 while row_cnt < BLACK_TAM_ROW/2.
- CAM_href = 1 while row_cnt >= BLACK_TAM_ROW and line_cnt < TAM_LINE.
- Pixel coordinates: x = line_cnt>>1, y = row_cnt-BLACK_TAM_ROW.
- Byte order: even line_cnt sends {4'b0,R}; odd line_cnt sends {G,B}.
- CAM_px_data = 0 whenever href=0.
- Pattern 1: bar = x/20, giving colours FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- Pattern 2: value = (y*160+x) mod 4096, 12 bits.
- Pattern 3: value = (x[3]^y[3]) ? FFF : 000.
- pattern and color are sampled at frame_start and held for the whole frame.

## Timing
- CAM_pclk is a register that toggles every PCLK_DIV clk cycles.
- Falling event: the clk edge where CAM_pclk goes 1->0. On this edge the counters advance and vsync, href, px_data, frame_start and frame_done update together.
- Consequence: all data is stable for a full half-period around each rising edge. The receiver samples on the rising edge.
- Pulses: frame_start and frame_done are high for exactly one clk, on the falling event.
- Reset (rst=0 at a clk edge) gives, on the next edge: CAM_pclk=0, vsync=0, href=0, px_data=0, pulses=0, counters=0, state IDLE. This applies mid-line and mid-frame as well. No partial line is emitted after reset release.
- Frame length: (TAM_LINE+BLACK_TAM_LINE)*(TAM_ROW+BLACK_TAM_ROW) pclk periods. Defaults: 324*124 = 40176 periods.
- Pixels per frame: 19200, which fits the 15-bit RAM address of the capture path.

## Structure
- Shared package cam_pkg holds:
  - the geometry parameter defaults;
  - the pattern codes;
  - the eight colour-bar constants.
- One natural sub-module, cam_pixel_pattern: combinational (x, y, pattern, color) -> 12-bit RGB444.
- Counters, FSM, pclk divider and byte mux live in cam_frame_gen.

## Test plan
- Reset and idle: rst=0 for 5 clk, then rst=1 with en=0 for 2000 clk -> vsync, href and px_data stay 0; CAM_pclk period is 4 clk (default PCLK_DIV).
- Frame geometry: en=1, pattern 0, color 12'hA5C. Measure from frame_start:
  - vsync high for 648 pclk periods;
  - 120 href pulses, each exactly 320 periods wide, with 4 low periods between them;
  - frame_done after 40176 periods;
  - bytes alternate 8'h0A and 8'h5C.
- Colour bars: pattern 1 -> line bytes 0-39 are 0F,FF; 40-79 are 0F,F0; 280-319 are 00,00.
- Ramp and checkerboard:
  - pattern 2, y=1 x=0 -> pixel 160 = 12'h0A0;
  - pattern 3, x=8 y=0 -> 12'hFFF.
- Stop/continue:
  - en dropped mid-frame -> the frame completes, then IDLE;
  - en held high -> back-to-back frames with frame_start on the edge after frame_done.
- Reset mid-frame: rst=0 at row 60 -> all outputs 0 on the next clk; after release with en=1, the next frame starts at row 0 with frame_start.
